// File: rtl/tas_pkg.sv
// Shared constants and types for the temperature averaging receive front end.
package tas_pkg;
  localparam logic [7:0] TAS_HDR_A     = 8'hA5;
  localparam logic [7:0] TAS_HDR_B     = 8'hC3;
  localparam int         TAS_NUM_TEMPS = 4;
  localparam int         SUM_W         = 10;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    TEMP = 2'd1,
    SKIP = 2'd2
  } rx_state_t;
endpackage

// File: rtl/tas_pkt_rx_if.sv
// Bus bundle between the serial source, the receive stage and the downstream consumer.
interface tas_pkt_rx_if;
  logic       serial_data;
  logic       data_ena;
  logic [7:0] avg_data;
  logic       avg_valid;
  logic       avg_ready;
  logic       avg_ovf;

  // avg_valid stays high with avg_data stable until the edge where avg_valid && avg_ready;
  // a new result arriving while valid is still pending overwrites avg_data and pulses avg_ovf.
  modport master (
    input  serial_data, data_ena, avg_ready,
    output avg_data, avg_valid, avg_ovf
  );

  modport slave (
    output serial_data, data_ena, avg_ready,
    input  avg_data, avg_valid, avg_ovf
  );
endinterface

// File: rtl/tas_pkt_rx_deser.sv
// LSB-first bit deserializer: gathers 8 data_ena-qualified bits into a byte and
// pulses byte_vld for one cycle after the eighth bit.
module tas_deser (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic       serial_data,
    input  logic       data_ena,
    output logic [7:0] byte_data,
    output logic       byte_vld
);

    logic [2:0] bitcnt;
    logic [6:0] shreg;

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            bitcnt    <= 3'd0;
            shreg     <= 7'd0;
            byte_data <= 8'd0;
            byte_vld  <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            if (data_ena) begin
                if (bitcnt == 3'd7) begin
                    // bit 7 goes straight into the output byte instead of the shift register
                    byte_data <= {serial_data, shreg};
                    byte_vld  <= 1'b1;
                    bitcnt    <= 3'd0;
                end else begin
                    shreg[bitcnt] <= serial_data;
                    bitcnt        <= bitcnt + 3'd1;
                end
            end else begin
                bitcnt <= 3'd0;
            end
        end
    end

endmodule

// File: rtl/tas_pkt_rx.sv
// Receive stage: frames header + NUM_TEMPS data bytes, averages temperature packets
// and presents the truncated average on a valid/ready output with overwrite flagging.
module tas_pkt_rx
    import tas_pkg::*;
#(
    parameter logic [7:0] HDR_A     = TAS_HDR_A,
    parameter logic [7:0] HDR_B     = TAS_HDR_B,
    parameter int         NUM_TEMPS = TAS_NUM_TEMPS
) (
    input  logic          clk_50,
    input  logic          reset_n,
    tas_pkt_rx_if.master  bus,
    output rx_state_t     state_dbg
);

    localparam int SHIFT = $clog2(NUM_TEMPS);
    localparam int CNT_W = (SHIFT > 0) ? SHIFT : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_TEMPS - 1);

    localparam logic [1:0] S_HDR  = HDR;
    localparam logic [1:0] S_TEMP = TEMP;
    localparam logic [1:0] S_SKIP = SKIP;

    logic [7:0]       byte_data;
    logic             byte_vld;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_next;
    logic [7:0]       avg_next;
    logic             new_result;

    tas_deser u_deser (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .serial_data (bus.serial_data),
        .data_ena    (bus.data_ena),
        .byte_data   (byte_data),
        .byte_vld    (byte_vld)
    );

    always_comb begin
        sum_next   = sum + SUM_W'(byte_data);
        avg_next   = 8'(sum_next >> SHIFT);
        new_result = byte_vld && (state == S_TEMP) && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state <= S_HDR;
            cnt   <= '0;
            sum   <= '0;
        end else if (byte_vld) begin
            case (state)
                S_HDR: begin
                    cnt   <= '0;
                    sum   <= '0;
                    state <= ((byte_data == HDR_A) || (byte_data == HDR_B)) ? S_TEMP : S_SKIP;
                end
                S_TEMP: begin
                    sum <= sum_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) state <= S_HDR;
                end
                S_SKIP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) state <= S_HDR;
                end
                default: state <= S_HDR;
            endcase
        end
    end

    // A result landing on the acceptance edge wins and is not counted as an overflow.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            bus.avg_data  <= 8'd0;
            bus.avg_valid <= 1'b0;
            bus.avg_ovf   <= 1'b0;
        end else begin
            bus.avg_ovf <= 1'b0;
            if (new_result) begin
                bus.avg_data  <= avg_next;
                bus.avg_valid <= 1'b1;
                bus.avg_ovf   <= bus.avg_valid && !bus.avg_ready;
            end else if (bus.avg_valid && bus.avg_ready) begin
                bus.avg_valid <= 1'b0;
            end
        end
    end

    assign state_dbg = rx_state_t'(state);

endmodule

// File: tb/tb_tas_pkt_rx.sv
// Self-checking bench for tas_pkt_rx: directed packets plus random traffic against a
// packet-level reference model, with a scoreboard monitor on the output handshake.
module tb_tas_pkt_rx;
  import tas_pkg::*;

  logic      clk_50;
  logic      reset_n;
  rx_state_t state_dbg;

  tas_pkt_rx_if bus ();

  tas_pkt_rx dut (
    .clk_50    (clk_50),
    .reset_n   (reset_n),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int exp_ovf = 0;
  int obs_ovf = 0;
  bit rand_ready = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pkt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: collect whole packets, average valid-header ones with integer division
  task automatic model_byte(input logic [7:0] b);
    int total;
    pkt_q.push_back(b);
    if (pkt_q.size() == 5) begin
      if (pkt_q[0] == 8'hA5 || pkt_q[0] == 8'hC3) begin
        total = 0;
        for (int i = 1; i < 5; i++) total += int'(pkt_q[i]);
        exp_q.push_back(8'(total / 4));
      end
      pkt_q.delete();
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk_50);
    #2;
    if (rand_ready) bus.avg_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.data_ena    = 1'b1;
      bus.serial_data = b[i];
      tick();
    end
  endtask

  task automatic idle(input int n);
    bus.data_ena    = 1'b0;
    bus.serial_data = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    model_byte(b);
    send_bits(b, 8);
    idle(gap);
  endtask

  task automatic send_pkt(input logic [7:0] h, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3, input int gap);
    send_byte(h, gap);
    send_byte(d0, gap);
    send_byte(d1, gap);
    send_byte(d2, gap);
    send_byte(d3, gap);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk_50) begin
    if (reset_n) begin
      if (bus.avg_ovf) begin
        obs_ovf++;
        if (exp_q.size() < 2) check("ovf_with_pending_result", exp_q.size(), 2);
        else void'(exp_q.pop_front());
      end
      if (bus.avg_valid && bus.avg_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", {24'd0, bus.avg_data}, 32'hFFFF_FFFF);
        else check("avg_data", {24'd0, bus.avg_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    bus.serial_data = 1'b0;
    bus.data_ena    = 1'b0;
    bus.avg_ready   = 1'b1;
    reset_n         = 1'b0;
    repeat (3) tick();
    check("reset_avg_valid", bus.avg_valid, 0);
    check("reset_avg_data", bus.avg_data, 0);
    check("reset_avg_ovf", bus.avg_ovf, 0);
    check("reset_state", state_dbg, HDR);
    reset_n = 1'b1;
    idle(2);

    // partial byte must be discarded, then light-side packet with 4-cycle gaps
    send_bits(8'hFF, 3);
    idle(1);
    send_pkt(8'hA5, 8'h3A, 8'h55, 8'h43, 8'h3C, 4);
    drain(50);

    // burst with latency check on the last byte
    send_byte(8'hA5, 1);
    send_byte(8'd10, 1);
    send_byte(8'd20, 1);
    send_byte(8'd30, 1);
    model_byte(8'd40);
    send_bits(8'd40, 8);
    check("latency_not_yet_valid", bus.avg_valid, 0);
    idle(1);
    check("latency_valid", bus.avg_valid, 1);
    check("latency_data", bus.avg_data, 25);
    idle(1);
    drain(50);

    // two packets with long mid-packet gaps
    send_byte(8'hA5, 2);
    send_byte(8'd18, 2);
    send_byte(8'd20, 200);
    send_byte(8'd22, 2);
    send_byte(8'd24, 2);
    send_byte(8'hC3, 2);
    send_byte(8'd26, 2);
    send_byte(8'd28, 150);
    send_byte(8'd30, 2);
    send_byte(8'd31, 2);
    drain(50);

    // non-temperature headers with embedded header-valued data
    send_pkt(8'h83, 8'hA5, 8'hC3, 8'hA5, 8'hC3, 1);
    send_pkt(8'hC1, 8'hC3, 8'hA5, 8'hA5, 8'hA5, 1);
    send_pkt(8'hA1, 8'hA5, 8'hC3, 8'hC3, 8'hA5, 1);
    idle(3);
    check("nontemp_no_valid", bus.avg_valid, 0);
    send_pkt(8'hA5, 8'd127, 8'd127, 8'd127, 8'd127, 1);
    drain(50);

    // overflow: downstream stalls across two results
    bus.avg_ready = 1'b0;
    exp_ovf++;
    send_pkt(8'hA5, 8'd5, 8'd5, 8'd5, 8'd5, 2);
    send_pkt(8'hA5, 8'd10, 8'd12, 8'd14, 8'd16, 2);
    idle(3);
    check("ovf_count", obs_ovf, exp_ovf);
    check("ovf_valid_held", bus.avg_valid, 1);
    check("ovf_data_latest", bus.avg_data, 13);
    bus.avg_ready = 1'b1;
    tick();
    check("accept_clears_valid", bus.avg_valid, 0);
    drain(10);

    // reset mid-packet and mid-byte, next byte starts right after the reset edge
    send_byte(8'hA5, 2);
    send_byte(8'd34, 2);
    send_byte(8'd36, 2);
    send_bits(8'hFF, 3);
    reset_n = 1'b0;
    pkt_q.delete();
    bus.data_ena = 1'b1;
    bus.serial_data = 1'b1;
    tick();
    check("midreset_state", state_dbg, HDR);
    check("midreset_valid", bus.avg_valid, 0);
    reset_n = 1'b1;
    send_pkt(8'hA5, 8'd34, 8'd36, 8'd38, 8'd40, 2);
    drain(50);

    // randomized traffic with random backpressure
    rand_ready = 1;
    for (int p = 0; p < 30; p++) begin
      logic [7:0] h;
      case ($urandom_range(0, 3))
        0:       h = 8'hA5;
        1:       h = 8'hC3;
        default: h = 8'($urandom_range(0, 255));
      endcase
      send_byte(h, $urandom_range(1, 5));
      for (int k = 0; k < 4; k++) send_byte(8'($urandom_range(0, 255)), $urandom_range(1, 5));
    end
    rand_ready = 0;
    bus.avg_ready = 1'b1;
    drain(100);
    idle(2);
    check("final_ovf_count", obs_ovf, exp_ovf);
    check("final_idle_valid", bus.avg_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
